// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_e;

  // Each FIFO entry carries {frame_err, parity_err, data}.
  localparam int FLAG_BITS = 2;

  function automatic int calc_div(input int clk_mhz, input int baud, input int ovs);
    return (clk_mhz * 1000000) / (baud * ovs);
  endfunction

  function automatic int entry_width(input int data_bits);
    return data_bits + FLAG_BITS;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO: head entry is visible on pop_data whenever not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-voted bit sampling, configurable framing,
// break detection and a FWFT receive FIFO.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_pin,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          break_det
);
  localparam int DIV = calc_div(CLK_FRE, BAUD_RATE, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int EW  = entry_width(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] T_VOTE    = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  rx_state_e state, state_next;

  logic                 sync1, rxs, rxs_d;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tcnt;
  logic                 s0, s1;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err, frm_err;
  logic                 push_q, brk_q;
  logic [EW-1:0]        push_data, head;
  logic                 fifo_full, fifo_empty;
  logic                 tick, vote, vote_tick, bit_end, start_det, brk_hit, stop_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign start_det = (state == S_IDLE) && rxs_d && !rxs;
  assign tick      = (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign vote      = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign vote_tick = tick && (tcnt == T_VOTE);
  assign bit_end   = tick && (tcnt == T_LAST);
  // Break: every data/parity bit and the first stop sample read low.
  assign brk_hit   = (state == S_STOP) && vote_tick && (stop_idx == 1'b0) &&
                     (shreg == '0) && !par_bit && !vote;
  assign stop_done = (state == S_STOP) && vote_tick && (stop_idx == STOP_LAST) && !brk_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (start_det) state_next = S_START;
      S_START: begin
        if (vote_tick && vote) state_next = S_IDLE;
        else if (bit_end)      state_next = S_DATA;
      end
      S_DATA:     if (bit_end && (bit_idx == LAST_BIT))
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY:   if (bit_end) state_next = S_STOP;
      S_STOP: begin
        if (brk_hit)        state_next = S_BRK_WAIT;
        else if (stop_done) state_next = S_IDLE;
      end
      S_BRK_WAIT: if (rxs) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      tcnt      <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      brk_q     <= 1'b0;
    end else begin
      push_q <= stop_done;
      brk_q  <= brk_hit;
      if (stop_done) push_data <= {frm_err | ~vote, par_err, shreg};

      // Bit phase is anchored to the start edge: counters idle at zero.
      if (state == S_IDLE) begin
        div_cnt <= '0;
        tcnt    <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
      end

      if (tick && (tcnt == T_S0)) s0 <= rxs;
      if (tick && (tcnt == T_S1)) s1 <= rxs;

      if (start_det) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        shreg    <= '0;
        par_bit  <= 1'b0;
        par_err  <= 1'b0;
        frm_err  <= 1'b0;
      end

      if (state == S_DATA) begin
        if (vote_tick) shreg   <= {vote, shreg[DATA_BITS-1:1]};
        if (bit_end)   bit_idx <= bit_idx + 4'd1;
      end

      if ((state == S_PARITY) && vote_tick) begin
        par_bit <= vote;
        par_err <= ((^shreg) ^ vote) != 1'(PARITY_ODD);
      end

      if (state == S_STOP) begin
        if (vote_tick && !vote) frm_err  <= 1'b1;
        if (bit_end)            stop_idx <= 1'b1;
      end
    end
  end

  // Read side: rx_valid means a head word is present; it is consumed on the
  // cycle rx_valid && rx_ready, and the head stays stable while rx_ready is low.
  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_data),
    .pop       (rx_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = head[DATA_BITS-1:0];
  assign rx_parity_err = head[DATA_BITS];
  assign rx_frame_err  = head[DATA_BITS+1];
  assign overflow      = push_q && fifo_full && !(rx_valid && rx_ready);
  assign break_det     = brk_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: 8N1 timing, parity, glitch/spike rejection,
// framing error, break, FIFO overflow/drain and mid-frame reset.
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int BIT = 432;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rx_line, rx_ready, rx_frame_err, rx_parity_err, rx_valid, overflow, break_det;
  logic [7:0] rx_data;
  logic [4:0] fifo_count;
  logic       rx_p, rx_ready_p, rx_frame_err_p, rx_parity_err_p, rx_valid_p, overflow_p, break_det_p;
  logic [7:0] rx_data_p;
  logic [4:0] fifo_count_p;
  logic       rx_f, rx_ready_f, rx_frame_err_f, rx_parity_err_f, rx_valid_f, overflow_f, break_det_f;
  logic [7:0] rx_data_f;
  logic [4:0] fifo_count_f;

  uart_rx_ovs dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_line), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .fifo_count(fifo_count), .overflow(overflow), .break_det(break_det)
  );

  uart_rx_ovs #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_p), .rx_data(rx_data_p),
    .rx_frame_err(rx_frame_err_p), .rx_parity_err(rx_parity_err_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .fifo_count(fifo_count_p), .overflow(overflow_p), .break_det(break_det_p)
  );

  uart_rx_ovs dut_f (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_f), .rx_data(rx_data_f),
    .rx_frame_err(rx_frame_err_f), .rx_parity_err(rx_parity_err_f), .rx_valid(rx_valid_f),
    .rx_ready(rx_ready_f), .fifo_count(fifo_count_f), .overflow(overflow_f), .break_det(break_det_f)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int brk_cnt = 0;
  int ovf_cnt_f = 0;
  int stray_cnt = 0;
  int t0;
  int k;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (break_det) brk_cnt <= brk_cnt + 1;
    if (overflow_f) ovf_cnt_f <= ovf_cnt_f + 1;
    if (overflow || overflow_p || break_det_p || break_det_f) stray_cnt <= stray_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx_line = v;
      1:       rx_p    = v;
      default: rx_f    = v;
    endcase
  endtask

  // Sends n bits LSB first; spike_bit gets a 20-clk low pulse around its middle sample.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int spike_bit);
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      for (int c = 0; c < BIT; c++) begin
        if (i == spike_bit && c == 235) drive(sel, 1'b0);
        if (i == spike_bit && c == 255) drive(sel, bits[i]);
        @(negedge clk);
      end
    end
  endtask

  task automatic pop_one(input int sel);
    case (sel)
      0:       rx_ready   = 1'b1;
      1:       rx_ready_p = 1'b1;
      default: rx_ready_f = 1'b1;
    endcase
    @(negedge clk);
    rx_ready = 1'b0;
    rx_ready_p = 1'b0;
    rx_ready_f = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_line = 1'b1; rx_p = 1'b1; rx_f = 1'b1;
    rx_ready = 1'b1; rx_ready_p = 1'b0; rx_ready_f = 1'b0;
    wait_clks(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_flags", {rx_frame_err, rx_parity_err, overflow, break_det}, 0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    rst_n = 1'b1;
    wait_clks(5);

    fork
      begin
        for (int i = 0; i < 17; i++) begin
          send_bits(2, 16'({1'b1, 8'(i), 1'b0}), 10, -1);
          if (i < 16) exp_q.push_back(8'(i));
        end
        wait_clks(20);
        check("fill_count", fifo_count_f, 16);
        check("fill_overflow_pulses", ovf_cnt_f, 1);
        check("fill_valid", rx_valid_f, 1);
        for (int i = 0; i < 16; i++) begin
          check("drain_data", rx_data_f, exp_q.pop_front());
          check("drain_flags", {rx_frame_err_f, rx_parity_err_f}, 0);
          pop_one(2);
        end
        check("drain_count", fifo_count_f, 0);
        check("drain_valid", rx_valid_f, 0);
      end
      begin
        t0 = cyc;
        send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 9, -1);
        drive(0, 1'b1);
        k = 0;
        while (!rx_valid && k < 600) begin
          @(negedge clk);
          k++;
        end
        check("a5_valid", rx_valid, 1);
        check_range("a5_latency", cyc - t0, 4158, 4170);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flags", {rx_frame_err, rx_parity_err}, 0);
        @(negedge clk);
        check("a5_pulse", rx_valid, 0);
        wait_clks(200);
        rx_ready = 1'b0;

        send_bits(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, -1);
        send_bits(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, -1);
        wait_clks(20);
        check("par_count", fifo_count_p, 2);
        check("par_bad_data", rx_data_p, 8'h03);
        check("par_bad_flag", rx_parity_err_p, 1);
        check("par_bad_frame", rx_frame_err_p, 0);
        pop_one(1);
        check("par_good_data", rx_data_p, 8'h03);
        check("par_good_flag", rx_parity_err_p, 0);
        pop_one(1);
        check("par_empty", rx_valid_p, 0);

        drive(0, 1'b0);
        wait_clks(100);
        drive(0, 1'b1);
        wait_clks(BIT - 100);
        check("glitch_state", 32'(dut.state), 32'(S_IDLE));
        check("glitch_count", fifo_count, 0);

        send_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10, 1);
        wait_clks(20);
        check("spike_count", fifo_count, 1);
        check("spike_data", rx_data, 8'hFF);
        check("spike_flags", {rx_frame_err, rx_parity_err}, 0);
        pop_one(0);

        send_bits(0, 16'({1'b0, 8'h55, 1'b0}), 10, -1);
        drive(0, 1'b1);
        wait_clks(20);
        check("ferr_count", fifo_count, 1);
        check("ferr_data", rx_data, 8'h55);
        check("ferr_flags", {rx_frame_err, rx_parity_err}, 2'b10);
        pop_one(0);

        drive(0, 1'b0);
        wait_clks(12 * BIT);
        drive(0, 1'b1);
        wait_clks(50);
        check("brk_pulses", brk_cnt, 1);
        check("brk_count", fifo_count, 0);

        send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
        wait_clks(20);
        check("post_brk_count", fifo_count, 1);
        check("post_brk_data", rx_data, 8'h3C);
        check("post_brk_flags", {rx_frame_err, rx_parity_err}, 0);
        check("post_brk_pulses", brk_cnt, 1);
      end
    join

    send_bits(0, 16'({1'b1, 8'h12, 1'b0}), 4, -1);
    drive(0, 1'b0);
    wait_clks(200);
    check("pre_rst_count", fifo_count, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_flags", {rx_frame_err, rx_parity_err, overflow, break_det}, 0);
    check("midrst_state", 32'(dut.state), 32'(S_IDLE));
    drive(0, 1'b1);
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    send_bits(0, 16'({1'b1, 8'h7E, 1'b0}), 10, -1);
    wait_clks(20);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_data", rx_data, 8'h7E);
    check("post_rst_flags", {rx_frame_err, rx_parity_err}, 0);
    check("stray_pulses", stray_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
